// File: rtl/histo_pkg.sv
// Shared constants and FSM state type for the ping-pong histogram controller.
package histo_pkg;

  localparam int unsigned BIN_W  = 20;
  localparam int unsigned ADDR_W = 8;

  localparam logic [BIN_W-1:0] BIN_MAX = {BIN_W{1'b1}};

  typedef enum logic [2:0] {
    StInitClr,
    StIdle,
    StAccum,
    StDrain,
    StScan,
    StPublish,
    StClear
  } state_e;

endpackage

// File: rtl/histo_rmw_pipe.sv
// Two-stage read-modify-write bin incrementer. The two most recent writes are
// forwarded so any run of identical pixels, even every cycle, counts exactly.
module histo_rmw_pipe
  import histo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W:0]   addr,
  input  logic [BIN_W-1:0]  rd_data,
  output logic              pend,
  output logic              we,
  output logic [ADDR_W:0]   wr_addr,
  output logic [BIN_W-1:0]  wr_data
);

  logic             v1_q, v2_q, v3_q;
  logic [ADDR_W:0]  a1_q, a2_q, a3_q;
  logic [BIN_W-1:0] d2_q, d3_q;
  logic [BIN_W-1:0] cur, nxt;

  // Stage 2 is being written this cycle; stage 3 was written last cycle and
  // may have collided with the read that is returning now.
  always_comb begin
    if (v2_q && (a2_q == a1_q)) begin
      cur = d2_q;
    end else if (v3_q && (a3_q == a1_q)) begin
      cur = d3_q;
    end else begin
      cur = rd_data;
    end
    nxt = (cur == BIN_MAX) ? cur : cur + BIN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge clk) begin
    a1_q <= addr;
    a2_q <= a1_q;
    d2_q <= nxt;
    a3_q <= a2_q;
    d3_q <= d2_q;
  end

  assign pend    = v1_q;
  assign we      = v2_q;
  assign wr_addr = a2_q;
  assign wr_data = d2_q;

endmodule

// File: rtl/histogram_bank_controller.sv
// Ping-pong histogram sequencer: accumulate, scan for max/quartiles, publish, clear.
// Optional HISTO_DROP_COUNT_EN adds a saturating oDropCount output.
module histogram_bank_controller
  import histo_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iFrameStart,
  input  logic              iFrameEnd,
  input  logic              iPixValid,
  input  logic [ADDR_W-1:0] iPixel,
  output logic [ADDR_W:0]   oRdAddr,
  input  logic [BIN_W-1:0]  iRdData,
  output logic              oWrEn,
  output logic [ADDR_W:0]   oWrAddr,
  output logic [BIN_W-1:0]  oWrData,
  output logic              oDispBank,
  output logic [BIN_W-1:0]  oMaxValue,
  output logic [ADDR_W-1:0] oThreshPoint25,
  output logic [ADDR_W-1:0] oThreshPoint50,
  output logic [ADDR_W-1:0] oThreshPoint75,
  output logic              oStatsValid,
  output logic              oBusy,
`ifdef HISTO_DROP_COUNT_EN
  output logic              oDrop,
  output logic [15:0]       oDropCount
`else
  output logic              oDrop
`endif
);

  state_e                       state_q;
  logic [ADDR_W:0]              cnt_q;
  logic                         wbank_q;
  logic [BIN_W-1:0]             n_q;
  logic [BIN_W+1:0]             c_q, c_sum;
  logic [BIN_W-1:0]             max_q;
  logic [2:0][ADDR_W-1:0]       thr_q;
  logic [2:0]                   found_q;
  logic                         rd_v_q;
  logic [ADDR_W-1:0]            rd_bin_q;
  logic                         clr_we_q;
  logic [ADDR_W:0]              clr_addr_q;
  logic [BIN_W+3:0]             c4;
  logic [2:0][BIN_W+3:0]        nk;
  logic                         pix_acc, pend, p_we, drop_evt;
  logic [ADDR_W:0]              p_addr;
  logic [BIN_W-1:0]             p_data;

  assign pix_acc  = (state_q == StAccum) && iPixValid;
  assign drop_evt = iFrameStart && (state_q != StIdle);
  assign oRdAddr  = {wbank_q, (state_q == StAccum) ? iPixel : cnt_q[ADDR_W-1:0]};
  assign oWrEn    = p_we | clr_we_q;
  assign oWrAddr  = p_we ? p_addr : clr_addr_q;
  assign oWrData  = p_we ? p_data : '0;
  assign oBusy    = !((state_q == StIdle) || (state_q == StAccum));

  // Threshold k is reached at the first bin where 4*C >= k*N.
  always_comb begin
    c_sum = c_q + {2'b00, iRdData};
    c4    = {c_sum, 2'b00};
    nk[0] = {4'b0000, n_q};
    nk[1] = {3'b000, n_q, 1'b0};
    nk[2] = nk[0] + nk[1];
  end

  histo_rmw_pipe u_rmw (
    .clk     (iClk),
    .rst_n   (iRst_n),
    .valid   (pix_acc),
    .addr    (oRdAddr),
    .rd_data (iRdData),
    .pend    (pend),
    .we      (p_we),
    .wr_addr (p_addr),
    .wr_data (p_data)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q        <= StInitClr;
      cnt_q          <= '0;
      wbank_q        <= 1'b0;
      oDispBank      <= 1'b1;
      oMaxValue      <= '0;
      oThreshPoint25 <= '0;
      oThreshPoint50 <= '0;
      oThreshPoint75 <= '0;
      oStatsValid    <= 1'b0;
      oDrop          <= 1'b0;
      n_q            <= '0;
      c_q            <= '0;
      max_q          <= '0;
      thr_q          <= '0;
      found_q        <= '0;
      rd_v_q         <= 1'b0;
      rd_bin_q       <= '0;
      clr_we_q       <= 1'b0;
      clr_addr_q     <= '0;
    end else begin
      oStatsValid <= 1'b0;
      clr_we_q    <= 1'b0;
      rd_v_q      <= 1'b0;
      oDrop       <= drop_evt;
      unique case (state_q)
        StInitClr: begin
          clr_we_q   <= 1'b1;
          clr_addr_q <= cnt_q;
          cnt_q      <= cnt_q + (ADDR_W+1)'(1);
          if (&cnt_q) state_q <= StIdle;
        end
        StIdle: begin
          if (iFrameStart) begin
            state_q <= StAccum;
            n_q     <= '0;
          end
        end
        StAccum: begin
          if (iPixValid && (n_q != BIN_MAX)) n_q <= n_q + BIN_W'(1);
          if (iFrameEnd) state_q <= StDrain;
        end
        StDrain: begin
          // The stage-2 write lands at this edge, ahead of the first scan read.
          if (!pend) begin
            state_q <= StScan;
            cnt_q   <= '0;
            c_q     <= '0;
            max_q   <= '0;
            found_q <= '0;
          end
        end
        StScan: begin
          if (rd_v_q) begin
            c_q <= c_sum;
            if (iRdData > max_q) max_q <= iRdData;
            for (int k = 0; k < 3; k++) begin
              if (!found_q[k] && (c4 >= nk[k])) begin
                found_q[k] <= 1'b1;
                thr_q[k]   <= rd_bin_q;
              end
            end
          end
          if (cnt_q[ADDR_W]) begin
            state_q <= StPublish;
            cnt_q   <= '0;
          end else begin
            rd_v_q   <= 1'b1;
            rd_bin_q <= cnt_q[ADDR_W-1:0];
            cnt_q    <= cnt_q + (ADDR_W+1)'(1);
          end
        end
        StPublish: begin
          oMaxValue      <= max_q;
          oThreshPoint25 <= thr_q[0];
          oThreshPoint50 <= thr_q[1];
          oThreshPoint75 <= thr_q[2];
          oDispBank      <= wbank_q;
          wbank_q        <= ~wbank_q;
          oStatsValid    <= 1'b1;
          state_q        <= StClear;
        end
        StClear: begin
          clr_we_q   <= 1'b1;
          clr_addr_q <= {wbank_q, cnt_q[ADDR_W-1:0]};
          if (cnt_q[ADDR_W-1:0] == '1) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + (ADDR_W+1)'(1);
          end
        end
        default: state_q <= StInitClr;
      endcase
    end
  end

`ifdef HISTO_DROP_COUNT_EN
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oDropCount <= '0;
    end else if (drop_evt && (oDropCount != 16'hFFFF)) begin
      oDropCount <= oDropCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_histogram_bank_controller.sv
// Bench for histogram_bank_controller: RAM model, write scoreboard, frame table.
module tb_histogram_bank_controller;
  import histo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, fs = 1'b0, fe = 1'b0, pv = 1'b0;
  logic [7:0]  pix = '0;
  logic [8:0]  rd_addr, wr_addr;
  logic [19:0] rd_data, wr_data, maxv;
  logic        we, disp, sv, busy, drop;
  logic [7:0]  t25, t50, t75;
`ifdef HISTO_DROP_COUNT_EN
  logic [15:0] drop_cnt;
`endif

  histogram_bank_controller dut (
    .iClk           (clk),
    .iRst_n         (rst_n),
    .iFrameStart    (fs),
    .iFrameEnd      (fe),
    .iPixValid      (pv),
    .iPixel         (pix),
    .oRdAddr        (rd_addr),
    .iRdData        (rd_data),
    .oWrEn          (we),
    .oWrAddr        (wr_addr),
    .oWrData        (wr_data),
    .oDispBank      (disp),
    .oMaxValue      (maxv),
    .oThreshPoint25 (t25),
    .oThreshPoint50 (t50),
    .oThreshPoint75 (t75),
    .oStatsValid    (sv),
    .oBusy          (busy),
    .oDrop          (drop)
`ifdef HISTO_DROP_COUNT_EN
    , .oDropCount   (drop_cnt)
`endif
  );

  // Simple dual-port RAM, read-first, 1-cycle read latency.
  logic [19:0] mem [512];
  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (we) mem[wr_addr] <= wr_data;
  end

  typedef struct packed {
    logic [8:0]  addr;
    logic [19:0] data;
  } wr_t;

  typedef struct {
    int          kind;
    int          npix;
    int          gap;
    int          drop_at;
    logic [19:0] emax;
    logic [7:0]  e25, e50, e75;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[5];
  int   checks = 0, errors = 0;
  int   drop_total = 0;
  logic wbank_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] gen_pix(input int kind, input int j);
    case (kind)
      0:       return 8'd37;
      1:       return 8'(j >> 2);
      default: return 8'((j * 53 + (j >> 4) * 7 + 11) & 255);
    endcase
  endfunction

  task automatic calc_exp(input int kind, input int npix, output logic [19:0] emax,
                          output logic [7:0] e25, output logic [7:0] e50, output logic [7:0] e75);
    int h[256];
    int c;
    bit [2:0] f;
    foreach (h[i]) h[i] = 0;
    for (int j = 0; j < npix; j++) h[gen_pix(kind, j)]++;
    c = 0; f = '0; emax = '0; e25 = '0; e50 = '0; e75 = '0;
    for (int i = 0; i < 256; i++) begin
      c += h[i];
      if (h[i] > int'(emax)) emax = 20'(h[i]);
      if (!f[0] && 4 * c >= npix)     begin f[0] = 1'b1; e25 = 8'(i); end
      if (!f[1] && 4 * c >= 2 * npix) begin f[1] = 1'b1; e50 = 8'(i); end
      if (!f[2] && 4 * c >= 3 * npix) begin f[2] = 1'b1; e75 = 8'(i); end
    end
  endtask

  task automatic do_reset();
    int lat;
    @(posedge clk); #1;
    rst_n = 1'b0; fs = 1'b0; fe = 1'b0; pv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_disp", disp, 1);
    chk("rst_wren", we, 0);
    chk("rst_max", maxv, 0);
    chk("rst_thresh", {t25, t50, t75}, 0);
    chk("rst_stats_valid", sv, 0);
    chk("rst_drop", drop, 0);
`ifdef HISTO_DROP_COUNT_EN
    chk("rst_drop_count", drop_cnt, 0);
`endif
    drop_total = 0;
    wbank_m = 1'b0;
    for (int i = 0; i < 512; i++) exp_q.push_back({9'(i), 20'd0});
    lat = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (!busy) begin lat = k; break; end
    end
    chk("init_cycles", lat, 512);
    chk("init_disp", disp, 1);
    @(negedge clk);
    chk("init_writes_left", exp_q.size(), 0);
  endtask

  task automatic run_frame(input int kind, input int npix, input int gap, input int drop_at,
                           input logic [19:0] emax, input logic [7:0] e25,
                           input logic [7:0] e50, input logic [7:0] e75);
    int h[256];
    int ok, got, drops, idle_k, mism;
    logic [7:0] p;
    foreach (h[i]) h[i] = 0;
    ok = 0;
    for (int k = 0; k < 700; k++) begin
      if (!busy) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("idle_before_frame", ok, 1);
    @(posedge clk); #1; fs = 1'b1;
    @(posedge clk); #1; fs = 1'b0;
    if (npix == 0) fe = 1'b1;
    for (int j = 0; j < npix; j++) begin
      p   = gen_pix(kind, j);
      pv  = 1'b1;
      pix = p;
      fe  = (j == npix - 1);
      h[p]++;
      exp_q.push_back({wbank_m, p, 20'(h[p])});
      if (j < npix - 1) begin
        @(posedge clk); #1;
        if (gap != 0) begin
          pv = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    @(posedge clk); #1;
    pv = 1'b0; fe = 1'b0;
    for (int i = 0; i < 256; i++) exp_q.push_back({~wbank_m, 8'(i), 20'd0});
    got = 0; drops = 0; idle_k = 0;
    for (int k = 1; k <= 800; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      fs  = (drop_at != 0) && (k == drop_at);
      pv  = fs;
      pix = 8'd9;
      @(negedge clk);
      if (drop) drops++;
      if (sv) begin
        got++;
        chk("max_value", maxv, emax);
        chk("thresh25", t25, e25);
        chk("thresh50", t50, e50);
        chk("thresh75", t75, e75);
        chk("disp_bank", disp, wbank_m);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[{disp, 8'(i)}] !== 20'(h[i])) mism++;
        chk("published_bins", mism, 0);
      end
      if (!busy) begin idle_k = k; break; end
    end
    fs = 1'b0; pv = 1'b0;
    chk("stats_pulses", got, 1);
    chk("drop_pulses", drops, (drop_at != 0) ? 1 : 0);
    chk("frame_end_to_idle", (idle_k > 0) && (idle_k <= 517), 1);
    wbank_m = ~wbank_m;
    if (drop_at != 0) drop_total++;
`ifdef HISTO_DROP_COUNT_EN
    chk("drop_count", drop_cnt, drop_total);
`endif
  endtask

  initial begin
    int hh[4];
    logic [19:0] m;
    logic [7:0]  a, b, c;

    fork
      forever begin
        @(negedge clk);
        if (we) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%0d required=no write", wr_addr);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", wr_addr, mon_e.addr);
            chk("wr_data", wr_data, mon_e.data);
          end
        end
      end
    join_none

    vecs[0] = '{0, 1000, 0, 0,   20'd1000, 8'd37, 8'd37,  8'd37};
    vecs[1] = '{1, 1024, 0, 0,   20'd4,    8'd63, 8'd127, 8'd191};
    vecs[2] = '{0, 0,    0, 0,   20'd0,    8'd0,  8'd0,   8'd0};
    calc_exp(2, 300, m, a, b, c);
    vecs[3] = '{2, 300,  1, 100, m,        a,     b,      c};
    vecs[4] = '{0, 5,    1, 0,   20'd5,    8'd37, 8'd37,  8'd37};

    do_reset();

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].kind, vecs[v].npix, vecs[v].gap, vecs[v].drop_at,
                vecs[v].emax, vecs[v].e25, vecs[v].e50, vecs[v].e75);
    end

    // Reset pulse in the middle of an accumulating frame.
    foreach (hh[i]) hh[i] = 0;
    @(posedge clk); #1; fs = 1'b1;
    @(posedge clk); #1; fs = 1'b0;
    for (int j = 0; j < 20; j++) begin
      pv  = 1'b1;
      pix = 8'(j & 3);
      hh[j & 3]++;
      exp_q.push_back({wbank_m, 8'(j & 3), 20'(hh[j & 3])});
      @(posedge clk); #1;
    end
    pv = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_writes_left", exp_q.size(), 0);
    do_reset();

    run_frame(1, 16, 0, 0, 20'd4, 8'd0, 8'd1, 8'd2);

    repeat (5) @(negedge clk);
    chk("final_writes_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
